// File: rtl/counter_monitor_pkg.sv
// counter_monitor_pkg: shared definitions for the counter sequence monitor.
//   - state_t: FSM state encoding (IDLE, SYNC, LOCK)
//   - DEFAULT_STALL_LIMIT / DEFAULT_CNT_W: default parameter values
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_STALL_LIMIT = 8;
  localparam int unsigned DEFAULT_CNT_W       = 8;

endpackage

// File: rtl/counter_monitor_if.sv
// counter_monitor_if: monitored counter bus plus monitor status outputs.
//   counter, valid                             : driven by the counter side (master)
//   locked, err, err_cnt, wrap_cnt, stall      : driven by the monitor (slave)
interface counter_monitor_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 8
);

  logic [WIDTH-1:0] counter;
  logic             valid;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] wrap_cnt;
  logic             stall;

  modport master (
    output counter, valid,
    input  locked, err, err_cnt, wrap_cnt, stall
  );

  modport slave (
    input  counter, valid,
    output locked, err, err_cnt, wrap_cnt, stall
  );

endinterface

// File: rtl/counter_stall_timer.sv
// counter_stall_timer: counts consecutive non-valid cycles while enabled.
//   clk, clear : clock, asynchronous active-high reset
//   enable     : monitor is in LOCK; timer is held at 0 otherwise
//   valid      : a sample this cycle restarts the count
//   expire     : high in the cycle that completes the STALL_LIMIT-th idle cycle
module counter_stall_timer #(
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  input  logic valid,
  output logic expire
);

  localparam int unsigned TW = $clog2(STALL_LIMIT + 1);

  logic [TW-1:0] count_q, count_d;

  // count_q holds the number of already completed idle cycles, so the current
  // idle cycle is the last one when count_q reaches STALL_LIMIT-1.
  assign expire = enable && !valid && (count_q == TW'(STALL_LIMIT - 1));

  always_comb begin
    count_d = count_q + TW'(1);
    if (!enable || valid || expire) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: in-design checker for a free-running binary counter bus.
// Locks onto the +1 sequence, pulses err on skipped/repeated values, counts
// errors (saturating) and max->0 wraps (modulo), and flags a stall when the
// bus goes unsampled for STALL_LIMIT cycles while locked.
//   clk, clear : clock, asynchronous active-high reset (highest priority)
//   bus        : counter_monitor_if slave (counter, valid in; status out)
// Optional feature: define COUNTER_MONITOR_CLEAR_TOLERANT_EN to accept an
// unexpected 0 while locked as an upstream counter clear (no error, stay locked).
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned STALL_LIMIT = DEFAULT_STALL_LIMIT,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input logic              clk,
  input logic              clear,
  counter_monitor_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             stall_q, stall_d;

  logic             expire;
  logic             in_seq;
  logic             is_wrap;
  logic             upstream_clear;

  assign in_seq  = bus.counter == (prev_q + WIDTH'(1));
  assign is_wrap = (prev_q == '1) && (bus.counter == '0);

`ifdef COUNTER_MONITOR_CLEAR_TOLERANT_EN
  assign upstream_clear = bus.counter == '0;
`else
  assign upstream_clear = 1'b0;
`endif

  counter_stall_timer #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_timer (
    .clk   (clk),
    .clear (clear),
    .enable(state_q == LOCK),
    .valid (bus.valid),
    .expire(expire)
  );

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    stall_d    = stall_q;

    // Every sample updates prev and ends a stall, whatever the state.
    if (bus.valid) begin
      prev_d  = bus.counter;
      stall_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (bus.valid && in_seq) begin
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (expire) begin
          state_d = IDLE;
          stall_d = 1'b1;
        end else if (bus.valid) begin
          if (in_seq) begin
            if (is_wrap) begin
              wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
            end
          end else if (!upstream_clear) begin
            // A repeat (counter == prev) lands here too.
            err_d   = 1'b1;
            state_d = SYNC;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.locked   = state_q == LOCK;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.stall    = stall_q;

endmodule
